// File: rtl/mem_stage_pkg.sv
// Shared widths, stall encoding and the EX->MEM bus layout for the memory stage.
package mem_stage_pkg;

    localparam int   StallBus     = 6;
    localparam logic Stop         = 1'b1;
    localparam logic NoStop       = 1'b0;
    localparam int   HILO_WD      = 66;
    localparam int   EX_TO_MEM_WD = 154;
    localparam int   MEM_TO_WB_WD = 136;
    localparam int   MEM_TO_RF_WD = 104;

    // mem_op bits, MSB first: lb, lbu, lh, lhu, lw, sb, sh, sw
    typedef struct packed {
        logic [7:0]         mem_op;
        logic [HILO_WD-1:0] hilo_bus;
        logic [31:0]        pc;
        logic               data_ram_en;
        logic [3:0]         data_ram_wen;
        logic [3:0]         data_ram_sel;
        logic               sel_rf_res;
        logic               rf_we;
        logic [4:0]         rf_waddr;
        logic [31:0]        ex_result;
    } ex_to_mem_t;

endpackage

// File: rtl/mem_load_align.sv
// Load-data alignment and sign/zero extension; purely combinational.
// mem_op = {lb, lbu, lh, lhu, lw}; misaligned halfwords fall back to the full word.
module mem_load_align (
    input  logic [4:0]  mem_op,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] data
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata[{addr, 3'b000} +: 8];
        half_v = rdata[{addr[1], 4'b0000} +: 16];
        data   = rdata;
        if (mem_op[4])
            data = {{24{byte_v[7]}}, byte_v};
        else if (mem_op[3])
            data = {24'b0, byte_v};
        else if (mem_op[2] && !addr[0])
            data = {{16{half_v[15]}}, half_v};
        else if (mem_op[1] && !addr[0])
            data = {16'b0, half_v};
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, load-data hold buffer across stalls, writeback select.
// One register stage of latency; stall[3] holds/bubbles the register, stall[4] decides bubble vs hold.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [StallBus-1:0]     stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus
);
    ex_to_mem_t  ex_to_mem_bus_r;
    logic [31:0] rdata_buf;
    logic        buf_valid;
    logic        capture;
    logic        bubble;
    logic        is_load;
    logic [31:0] eff_rdata;
    logic [31:0] load_data;
    logic [31:0] rf_wdata;
    logic        unused_bits;

    assign capture = (stall[3] == NoStop);
    assign bubble  = (stall[3] == Stop) && (stall[4] == NoStop);
    assign is_load = |ex_to_mem_bus_r.mem_op[7:3];

    // SRAM data is only valid for one cycle, so a load stuck in MEM keeps its own copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_to_mem_bus_r <= '0;
            rdata_buf       <= '0;
            buf_valid       <= 1'b0;
        end else if (bubble) begin
            ex_to_mem_bus_r <= '0;
            buf_valid       <= 1'b0;
        end else if (capture) begin
            ex_to_mem_bus_r <= ex_to_mem_t'(ex_to_mem_bus);
            buf_valid       <= 1'b0;
        end else if (is_load && !buf_valid) begin
            rdata_buf <= data_sram_rdata;
            buf_valid <= 1'b1;
        end
    end

    assign eff_rdata = buf_valid ? rdata_buf : data_sram_rdata;

    mem_load_align u_align (
        .mem_op (ex_to_mem_bus_r.mem_op[7:3]),
        .addr   (ex_to_mem_bus_r.ex_result[1:0]),
        .rdata  (eff_rdata),
        .data   (load_data)
    );

    assign rf_wdata = ex_to_mem_bus_r.sel_rf_res ? load_data : ex_to_mem_bus_r.ex_result;

    assign mem_to_wb_bus = {ex_to_mem_bus_r.hilo_bus, ex_to_mem_bus_r.pc,
                            ex_to_mem_bus_r.rf_we, ex_to_mem_bus_r.rf_waddr, rf_wdata};
    assign mem_to_rf_bus = {ex_to_mem_bus_r.hilo_bus,
                            ex_to_mem_bus_r.rf_we, ex_to_mem_bus_r.rf_waddr, rf_wdata};

    // Store controls were consumed in EX; they ride along only for debug.
    assign unused_bits = ^{stall[5], stall[2:0], ex_to_mem_bus_r.data_ram_en,
                           ex_to_mem_bus_r.data_ram_wen, ex_to_mem_bus_r.data_ram_sel,
                           ex_to_mem_bus_r.mem_op[2:0]};

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed load/stall/reset scenarios, then random traffic vs a reference model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam logic [7:0] OP_LB  = 8'h80;
    localparam logic [7:0] OP_LBU = 8'h40;
    localparam logic [7:0] OP_LH  = 8'h20;
    localparam logic [7:0] OP_LHU = 8'h10;
    localparam logic [7:0] OP_LW  = 8'h08;
    localparam logic [7:0] OP_ALU = 8'h00;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [StallBus-1:0]     stall;
    logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
    logic [31:0]             data_sram_rdata;
    logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
    logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: the instruction currently in MEM, plus the load data it has already seen.
    ex_to_mem_t  m        = '0;
    logic        held     = 1'b0;
    logic [31:0] held_dat = '0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .data_sram_rdata (data_sram_rdata),
        .mem_to_wb_bus   (mem_to_wb_bus),
        .mem_to_rf_bus   (mem_to_rf_bus)
    );

    task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [7:0] op, input logic [1:0] a,
                                             input logic [31:0] d);
        int unsigned v;
        if (op == OP_LB || op == OP_LBU) begin
            v = (d >> (8 * a)) & 32'hFF;
            if (op == OP_LB && v >= 128) v = v | 32'hFFFF_FF00;
            return v;
        end
        if ((op == OP_LH || op == OP_LHU) && (a % 2 == 0)) begin
            v = (d >> (16 * (a / 2))) & 32'hFFFF;
            if (op == OP_LH && v >= 32768) v = v | 32'hFFFF_0000;
            return v;
        end
        return d;
    endfunction

    function automatic ex_to_mem_t mk(input logic [7:0] op, input logic [31:0] pc, input logic we,
                                      input logic [4:0] wa, input logic [31:0] res);
        ex_to_mem_t b;
        b              = '0;
        b.mem_op       = op;
        b.hilo_bus     = {2'($urandom), $urandom, $urandom};
        b.pc           = pc;
        b.data_ram_en  = |op;
        b.data_ram_sel = 4'($urandom);
        b.sel_rf_res   = |op[7:3];
        b.rf_we        = we;
        b.rf_waddr     = wa;
        b.ex_result    = res;
        return b;
    endfunction

    function automatic ex_to_mem_t rand_bus();
        int unsigned idx;
        logic [7:0]  op;
        idx = $urandom_range(0, 8);
        op  = (idx == 0) ? OP_ALU : (8'h80 >> (idx - 1));
        return mk(op, $urandom, (idx >= 6) ? 1'b0 : 1'($urandom), 5'($urandom), $urandom);
    endfunction

    // Drive one cycle's inputs, then at the falling edge compare both buses with the model.
    task automatic apply(input logic r, input logic [5:0] st, input ex_to_mem_t b,
                         input logic [31:0] rd);
        logic [31:0] eff;
        logic [31:0] wd;
        rst             = r;
        stall           = st;
        ex_to_mem_bus   = b;
        data_sram_rdata = rd;
        @(negedge clk);
        eff = held ? held_dat : rd;
        wd  = m.sel_rf_res ? ref_load(m.mem_op, m.ex_result[1:0], eff) : m.ex_result;
        chk("wb_bus", mem_to_wb_bus, {m.hilo_bus, m.pc, m.rf_we, m.rf_waddr, wd});
        chk("rf_bus", mem_to_rf_bus, {m.hilo_bus, m.rf_we, m.rf_waddr, wd});
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m    = '0;
            held = 1'b0;
        end else if (stall[3] && !stall[4]) begin
            m    = '0;
            held = 1'b0;
        end else if (!stall[3]) begin
            m    = ex_to_mem_t'(ex_to_mem_bus);
            held = 1'b0;
        end else if (|m.mem_op[7:3] && !held) begin
            held     = 1'b1;
            held_dat = data_sram_rdata;
        end
        #1;
    endtask

    initial begin
        ex_to_mem_t bx;
        ex_to_mem_t alu;
        rst             = 1'b1;
        stall           = '0;
        ex_to_mem_bus   = '0;
        data_sram_rdata = '0;
        tick();

        apply(1'b0, 6'b011000, mk(OP_LW, 32'h100, 1'b1, 5'd9, 32'h0), 32'hDEAD_BEEF);
        chk("reset_wb_zero", mem_to_wb_bus, 136'h0);
        chk("reset_rf_zero", mem_to_rf_bus, 136'h0);
        tick();

        apply(1'b0, 6'b000000, mk(OP_LB, 32'h200, 1'b1, 5'd3, 32'h1003), 32'h0);
        tick();
        apply(1'b0, 6'b000000, mk(OP_LBU, 32'h204, 1'b1, 5'd3, 32'h1003), 32'h80AB_CDEF);
        chk("lb_sext", mem_to_wb_bus[31:0], 32'hFFFF_FF80);
        tick();
        apply(1'b0, 6'b000000, mk(OP_LH, 32'h208, 1'b1, 5'd4, 32'h2002), 32'h80AB_CDEF);
        chk("lbu_zext", mem_to_wb_bus[31:0], 32'h0000_0080);
        tick();
        apply(1'b0, 6'b000000, mk(OP_LHU, 32'h20C, 1'b1, 5'd4, 32'h2000), 32'h8001_7FFF);
        chk("lh_sext", mem_to_wb_bus[31:0], 32'hFFFF_8001);
        tick();
        apply(1'b0, 6'b000000, mk(OP_LW, 32'h210, 1'b1, 5'd6, 32'h3000), 32'h8001_7FFF);
        chk("lhu_zext", mem_to_wb_bus[31:0], 32'h0000_7FFF);
        tick();

        alu = mk(OP_ALU, 32'h214, 1'b1, 5'd5, 32'h0000_0042);
        apply(1'b0, 6'b011000, alu, 32'h1111_1111);
        chk("lw_hold_0", mem_to_wb_bus[31:0], 32'h1111_1111);
        tick();
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, 6'b011000, alu, 32'h2222_2222);
            chk("lw_hold_n", mem_to_wb_bus[31:0], 32'h1111_1111);
            tick();
        end
        apply(1'b0, 6'b000000, alu, 32'h2222_2222);
        chk("lw_release", mem_to_wb_bus[31:0], 32'h1111_1111);
        tick();

        bx = mk(OP_LW, 32'h300, 1'b1, 5'd7, 32'h0);
        apply(1'b0, 6'b001000, bx, $urandom);
        chk("alu_wb", {mem_to_wb_bus[37], mem_to_wb_bus[36:32], mem_to_wb_bus[31:0]},
            {1'b1, 5'd5, 32'h42});
        chk("alu_rf", {mem_to_rf_bus[37], mem_to_rf_bus[36:32], mem_to_rf_bus[31:0]},
            {1'b1, 5'd5, 32'h42});
        tick();
        apply(1'b0, 6'b000000, bx, $urandom);
        chk("bubble_zero", mem_to_wb_bus, 136'h0);
        tick();
        apply(1'b0, 6'b011000, bx, 32'h3333_3333);
        chk("post_bubble_pc", mem_to_wb_bus[69:38], 32'h300);
        tick();
        apply(1'b1, 6'b011000, bx, 32'h4444_4444);
        chk("held_before_rst", mem_to_wb_bus[31:0], 32'h3333_3333);
        tick();
        bx = mk(OP_LW, 32'h400, 1'b1, 5'd8, 32'h0);
        apply(1'b0, 6'b000000, bx, 32'h5555_5555);
        chk("rst_mid_wb", mem_to_wb_bus, 136'h0);
        chk("rst_mid_rf", mem_to_rf_bus, 136'h0);
        tick();
        apply(1'b0, 6'b011000, bx, 32'h6666_6666);
        chk("after_rst_live", mem_to_wb_bus[31:0], 32'h6666_6666);
        tick();
        apply(1'b0, 6'b011000, bx, 32'h7777_7777);
        chk("after_rst_held", mem_to_wb_bus[31:0], 32'h6666_6666);
        tick();

        for (int i = 0; i < 3000; i++) begin
            int unsigned k;
            logic [5:0]  st;
            k  = $urandom_range(0, 9);
            st = 6'($urandom);
            if (k <= 5)      st[4:3] = {1'($urandom), 1'b0};
            else if (k <= 7) st[4:3] = 2'b11;
            else             st[4:3] = 2'b01;
            apply(($urandom_range(0, 49) == 0), st, rand_bus(), $urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL expose: clk  input  1  rising-edge clock (clk; all state updates on posedge).
REQ-002 SHALL expose: rst  input  1  reset rst, synchronous, active-high.
REQ-003 SHALL expose: stall  input  StallBus(6)  pipeline stall vector; bit3 = EX/MEM register, bit4 = MEM/WB register; 1 = Stop.
REQ-004 SHALL expose: ex_to_mem_bus  input  EX_TO_MEM_WD(154)  bus from the execute stage, MSB first:
- mem_op[8]: lb, lbu, lh, lhu, lw, sb, sh, sw
- hilo_bus[66]: hi_we, hi, lo_we, lo
- pc[32], data_ram_en, data_ram_wen[4], data_ram_sel[4], sel_rf_res, rf_we, rf_waddr[5], ex_result[32]
REQ-005 SHALL expose: data_sram_rdata  input  32  data-SRAM read data, valid the cycle after the address is issued in EX.
REQ-006 SHALL expose: mem_to_wb_bus  output  MEM_TO_WB_WD(136)  {hilo_bus, pc, rf_we, rf_waddr, rf_wdata}.
REQ-007 SHALL expose: mem_to_rf_bus  output  MEM_TO_RF_WD(104)  forwarding bus {hilo_bus, rf_we, rf_waddr, rf_wdata}.

Function
REQ-008 SHALL hold the EX/MEM pipeline register ex_to_mem_bus_r; update priority: rst -> 0; stall[3]=Stop and stall[4]=NoStop -> 0 (bubble); stall[3]=NoStop -> capture ex_to_mem_bus; otherwise hold.
REQ-009 SHALL decode all fields from ex_to_mem_bus_r only, never from the live input.
REQ-010 SHALL keep a 32-bit rdata buffer and a 1-bit buf_valid flag.
REQ-011 SHALL set buf_valid and load the buffer with data_sram_rdata on the first cycle in which stall[3]=Stop, stall[4]=Stop, the register holds a load, and buf_valid=0.
REQ-012 SHALL clear buf_valid on any cycle the register captures or bubbles.
REQ-013 SHALL use the effective read data: buffer when buf_valid=1, else data_sram_rdata.
REQ-014 SHALL align loads using addr = ex_result[1:0]:
- lb/lbu: byte addr*8, sign/zero-extended
- lh/lhu: halfword at addr[1]*16, sign/zero-extended
- lw: full word
REQ-015 SHALL treat misaligned lh/lhu (addr[0]=1) or lw (addr≠0) as lw of the effective data; no exception is raised here.
REQ-016 SHALL select rf_wdata = aligned load data when sel_rf_res=1, else ex_result.
REQ-017 SHALL pass hilo_bus, pc, rf_we and rf_waddr through unchanged; stores (sb/sh/sw) SHALL produce rf_we=0 as delivered.
REQ-018 SHALL drive mem_to_rf_bus from the same combinational values as mem_to_wb_bus within the same cycle.
REQ-019 SHALL have latency of one register stage: a capture at edge N appears on both output buses in cycle N.
REQ-020 SHALL resolve simultaneous events as follows: bubble beats the buffer-load condition; rst beats everything.

Reset
REQ-021 SHALL clear ex_to_mem_bus_r, buffer and buf_valid on rst; both output buses SHALL then read all-zero (rf_we=0, hi_we=0, lo_we=0).
REQ-022 SHALL discard any in-flight load when rst is asserted mid-stall; the next instruction SHALL use live rdata.

Structure
REQ-023 SHALL place StallBus, Stop/NoStop, EX_TO_MEM_WD, MEM_TO_WB_WD, MEM_TO_RF_WD and HILO_WD(66) in the shared defines header.
REQ-024 SHALL implement load alignment and extension as one combinational sub-module, mem_load_align, with inputs (mem_op[4:0], addr[1:0], rdata) and output (data[31:0]).

Verification
REQ-025 SHALL pass: lb, ex_result=0x1003, rdata=0x80AB_CDEF, sel_rf_res=1 -> rf_wdata=0xFFFF_FF80; same with lbu -> 0x0000_0080.
REQ-026 SHALL pass: lh, addr=0x2, rdata=0x8001_7FFF -> 0xFFFF_8001; lhu, addr=0x0 -> 0x0000_7FFF.
REQ-027 SHALL pass: lw captured, then stall=6'b011000 for 3 cycles while rdata changes 0x1111_1111 -> 0x2222_2222 -> rf_wdata stays 0x1111_1111 throughout.
REQ-028 SHALL pass: stall[3]=Stop, stall[4]=NoStop -> next cycle mem_to_wb_bus all-zero; the register then captures when stall clears.
REQ-029 SHALL pass: addu result 0x0000_0042, rf_we=1, waddr=5 -> both buses show rf_we=1, waddr=5, wdata=0x42 in the same cycle.
REQ-030 SHALL pass: rst asserted during a held load -> buses zero next cycle; buf_valid=0; the following lw returns live rdata.
